layer1_drain: RTL and testbench
===============================

Name: layer1_drain

Overview:
- Downstream consumer of the layer-1 MAC array.
- Captures the ten 16-bit accumulated column results when the sequencer flags accumulation complete.
- Applies a shared bias, signed saturation and ReLU to each lane.
- Serializes the ten results one per cycle over a valid/ready stream toward the layer-2 input buffer.

Parameters:
- LANES, 10, number of MAC lanes captured per frame.
- DW, 16, lane data width (signed two's complement).

Ports:
- clk  input  1  single clock, rising edge.
- globalReset  input  1  synchronous reset, active-low.
- col_valid  input  1  column bus holds final accumulated values for this frame.
- col_ready  output  1  block can capture a frame.
- column  input  LANES*DW  lane i at bits [DW*i+DW-1 : DW*i].
- bias  input  DW  signed bias; sampled together with column.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  DW  activated lane result.
- out_index  output  4  lane number of out_data, 0..LANES-1.
- out_last  output  1  high while out_index == LANES-1 and out_valid.
- frame_done  output  1  one-cycle pulse after the final lane handshake.
- sat_sticky  output  1  set if any lane saturated positive; cleared only by reset.

Behaviour:
- Reset (globalReset==0 at a clk edge): state IDLE, col_ready=0, out_valid=0, out_index=0, out_last=0, frame_done=0, sat_sticky=0, result registers 0. This takes priority over every other event and abandons any frame in flight.
- col_ready is registered and equals (state==IDLE). It is 1 from the first cycle after reset deasserts.
- FSM IDLE:
  - col_ready=1.
  - On col_valid==1 at an edge: compute all lanes and store them in LANES result registers, set out_index=0, go to SEND.
  - out_valid=1 in the cycle following the capture edge (latency 1).
- Lane arithmetic:
  - s = sign-extend(column_i) + sign-extend(bias), DW+1 bits.
  - If s > 32767, r = 32767 and sat_sticky is set.
  - If s < -32768, r = -32768.
  - Then ReLU: r < 0 gives 0, otherwise r.
  - Result is always in 0..32767.
- FSM SEND:
  - out_valid=1, out_data = result[out_index], out_last = (out_index==LANES-1).
  - Handshake is out_valid && out_ready at the edge.
  - No handshake: out_data, out_index and out_last are held stable, with no limit on stall length.
  - Handshake and out_index < LANES-1: out_index increments.
  - Handshake on the last lane: go to IDLE, out_valid=0 next cycle, frame_done=1 for exactly that next cycle, col_ready=1 next cycle.
- col_valid while in SEND is ignored (col_ready=0). The upstream sequencer holds column and col_valid until it sees col_ready.
- Throughput: LANES+1 cycles minimum per frame, because one IDLE cycle separates frames.
- out_ready is never used combinationally to drive col_ready or out_valid. All outputs are registered or are a mux of registers.
- Changes to column or bias after the capture edge do not affect results already stored.

Test Plan:
1. Reset, then col_valid with lanes 0..9 = 1..10 (0x0001..0x000A), bias=0, out_ready=1 → out_valid rises 1 cycle after capture; out_data 1,2,...,10 on consecutive cycles; out_last on the 10th; frame_done pulse the next cycle; col_ready back to 1.
2. Lanes = 0x7FF0, 0x8000, 0xFFFF, 0x0005, rest 0; bias=0x0020 → out_data 0x7FFF (sat_sticky=1), 0x0000, 0x001F, 0x0025, then 0x0020 for the remaining six lanes.
3. Bias=0xFFF0 (-16), all lanes 0x0008 → all ten outputs 0x0000; sat_sticky stays 0.
4. out_ready toggles 1,0,0,1,0,1... during a frame → each lane is presented until accepted; none dropped or duplicated; out_index is monotonic 0..9; data stable throughout each stall.
5. Second col_valid asserted continuously during SEND with different data → ignored until IDLE; the captured second frame matches the data present on the cycle col_ready=1.
6. globalReset=0 asserted at out_index=4 mid-frame → next cycle out_valid=0, col_ready=0, sat_sticky=0. After release, col_ready=1 and a new frame starts at out_index=0.

Source files
------------

// File: rtl/layer1_drain.sv
// layer1_drain: captures a frame of MAC column sums, applies bias/saturation/ReLU, streams lanes out one per cycle.
module layer1_drain #(
    parameter int LANES = 10,
    parameter int DW    = 16
) (
    input  logic              clk,
    input  logic              globalReset,
    input  logic              col_valid,
    output logic              col_ready,
    input  logic [LANES*DW-1:0] column,
    input  logic [DW-1:0]     bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [3:0]        out_index,
    output logic              out_last,
    output logic              frame_done,
    output logic              sat_sticky
);
    localparam int IW = 4;
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nx;
    logic [DW-1:0] result [LANES];
    logic [DW-1:0] act [LANES];
    logic [DW:0] sum [LANES];
    logic any_sat, capture, hs, last;
    // DW+1-bit sum: top bit set means negative (ReLU to 0); bit DW-1 set on a non-negative sum means positive overflow
    always_comb begin
        any_sat = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            sum[i] = {column[DW*i+DW-1], column[DW*i +: DW]} + {bias[DW-1], bias};
            act[i] = sum[i][DW] ? '0 : (sum[i][DW-1] ? {1'b0, {(DW-1){1'b1}}} : sum[i][DW-1:0]);
            any_sat = any_sat | (!sum[i][DW] && sum[i][DW-1]);
        end
    end
    always_comb begin
        capture  = (state == IDLE) && col_ready && col_valid;
        hs       = (state == SEND) && out_ready;
        last     = (out_index == IW'(LANES-1));
        state_nx = capture ? SEND : ((hs && last) ? IDLE : state);
    end
    assign out_valid = (state == SEND);
    assign out_last  = out_valid && last;
    assign out_data  = result[out_index];
    always_ff @(posedge clk) begin
        if (!globalReset) begin
            state      <= IDLE;
            col_ready  <= 1'b0;
            out_index  <= '0;
            frame_done <= 1'b0;
            sat_sticky <= 1'b0;
            for (int i = 0; i < LANES; i++) result[i] <= '0;
        end else begin
            state      <= state_nx;
            col_ready  <= (state_nx == IDLE);
            frame_done <= hs && last;
            if (capture) begin
                result     <= act;
                out_index  <= '0;
                sat_sticky <= sat_sticky | any_sat;
            end else if (hs) begin
                out_index <= last ? '0 : out_index + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_layer1_drain.sv
// tb_layer1_drain: directed and randomized frames checked against an integer-arithmetic lane model.
module tb_layer1_drain;
    typedef logic [15:0] lanes_t [10];
    logic clk = 1'b0;
    logic globalReset = 1'b0;
    logic col_valid = 1'b0;
    logic col_ready;
    logic [159:0] column = '0;
    logic [15:0] bias = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0] out_index;
    logic out_last;
    logic frame_done;
    logic sat_sticky;
    int checks = 0;
    int failures = 0;
    bit exp_sticky = 1'b0;

    layer1_drain dut (
        .clk(clk), .globalReset(globalReset), .col_valid(col_valid), .col_ready(col_ready),
        .column(column), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .frame_done(frame_done), .sat_sticky(sat_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lane_model(input logic [15:0] c, input logic [15:0] b, output bit sat);
        int s;
        s = int'($signed(c)) + int'($signed(b));
        sat = 1'b0;
        if (s > 32767) begin
            s = 32767;
            sat = 1'b1;
        end
        if (s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic drive_column(input lanes_t l);
        for (int i = 0; i < 10; i++) column[16*i +: 16] = l[i];
    endtask

    // mode 0: always ready, 1: fixed 1,0,0,1,0,1 pattern, 2: random ready
    task automatic send_frame(input lanes_t l, input logic [15:0] b, input int mode,
                              input bit keep_valid, input lanes_t nxt);
        logic [15:0] exp [10];
        bit sat;
        int n, k, cyc, p;
        bit r;
        bit pat [6] = '{1, 0, 0, 1, 0, 1};
        drive_column(l);
        bias = b;
        col_valid = 1'b1;
        n = 0;
        while (!col_ready && n < 50) begin
            step();
            n++;
        end
        chk("col_ready_wait", {31'b0, col_ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            exp[i] = lane_model(l[i], b, sat);
            if (sat) exp_sticky = 1'b1;
        end
        step();
        if (keep_valid) begin
            drive_column(nxt);
            bias = ~b;
        end else begin
            col_valid = 1'b0;
            column = {5{32'hDEAD_BEEF}};
            bias = 16'h7FFF;
        end
        chk("latency_valid", {31'b0, out_valid}, 32'd1);
        chk("col_ready_busy", {31'b0, col_ready}, 32'd0);
        chk("sticky", {31'b0, sat_sticky}, {31'b0, exp_sticky});
        k = 0;
        cyc = 0;
        p = 0;
        while (k < 10 && cyc < 300) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[p % 6] : 1'($urandom_range(0, 1));
            p++;
            out_ready = r;
            chk("out_valid", {31'b0, out_valid}, 32'd1);
            chk("out_index", {28'b0, out_index}, k);
            chk("out_data", {16'b0, out_data}, {16'b0, exp[k]});
            chk("out_last", {31'b0, out_last}, {31'b0, k == 9});
            chk("col_ready_send", {31'b0, col_ready}, 32'd0);
            step();
            if (r) k++;
            cyc++;
        end
        chk("lane_count", k, 32'd10);
        out_ready = 1'b0;
        chk("end_valid", {31'b0, out_valid}, 32'd0);
        chk("frame_done", {31'b0, frame_done}, 32'd1);
        chk("end_col_ready", {31'b0, col_ready}, 32'd1);
        if (!keep_valid) begin
            step();
            chk("frame_done_pulse", {31'b0, frame_done}, 32'd0);
            chk("idle_valid", {31'b0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        lanes_t a, b2, z;
        for (int i = 0; i < 10; i++) z[i] = '0;
        // reset
        globalReset = 1'b0;
        repeat (3) step();
        chk("rst_col_ready", {31'b0, col_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_index", {28'b0, out_index}, 32'd0);
        chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
        chk("rst_sticky", {31'b0, sat_sticky}, 32'd0);
        globalReset = 1'b1;
        step();
        chk("post_rst_col_ready", {31'b0, col_ready}, 32'd1);
        // test 1: ramp
        for (int i = 0; i < 10; i++) a[i] = 16'(i + 1);
        send_frame(a, 16'h0000, 0, 1'b0, z);
        // test 2: saturation corners
        for (int i = 0; i < 10; i++) a[i] = 16'h0000;
        a[0] = 16'h7FF0; a[1] = 16'h8000; a[2] = 16'hFFFF; a[3] = 16'h0005;
        exp_sticky = 1'b0;
        send_frame(a, 16'h0020, 0, 1'b0, z);
        chk("sticky_set", {31'b0, sat_sticky}, 32'd1);
        // test 3 runs after a reset so the sticky flag starts clear
        globalReset = 1'b0;
        step();
        globalReset = 1'b1;
        exp_sticky = 1'b0;
        step();
        for (int i = 0; i < 10; i++) a[i] = 16'h0008;
        send_frame(a, 16'hFFF0, 0, 1'b0, z);
        chk("sticky_clear", {31'b0, sat_sticky}, 32'd0);
        // test 4: stalls
        for (int i = 0; i < 10; i++) a[i] = 16'($urandom);
        send_frame(a, 16'($urandom), 1, 1'b0, z);
        // test 5: col_valid held during SEND with new data
        for (int i = 0; i < 10; i++) begin
            a[i] = 16'($urandom);
            b2[i] = 16'($urandom);
        end
        send_frame(a, 16'h1234, 2, 1'b1, b2);
        send_frame(b2, 16'h1234 ^ 16'hFFFF, 0, 1'b0, z);
        // randomized frames
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 10; i++) a[i] = 16'($urandom);
            send_frame(a, 16'($urandom), 2, 1'b0, z);
        end
        // test 6: reset mid-frame at out_index 4 after sticky is set
        for (int i = 0; i < 10; i++) a[i] = 16'h7FFF;
        drive_column(a);
        bias = 16'h0100;
        col_valid = 1'b1;
        step();
        col_valid = 1'b0;
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (out_index != 4'd4 && n < 20) begin
                step();
                n++;
            end
        end
        chk("mid_index", {28'b0, out_index}, 32'd4);
        chk("mid_sticky", {31'b0, sat_sticky}, 32'd1);
        out_ready = 1'b0;
        globalReset = 1'b0;
        step();
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_col_ready", {31'b0, col_ready}, 32'd0);
        chk("mid_rst_sticky", {31'b0, sat_sticky}, 32'd0);
        chk("mid_rst_index", {28'b0, out_index}, 32'd0);
        globalReset = 1'b1;
        exp_sticky = 1'b0;
        step();
        chk("mid_post_col_ready", {31'b0, col_ready}, 32'd1);
        for (int i = 0; i < 10; i++) a[i] = 16'(100 * i);
        send_frame(a, 16'hFF00, 0, 1'b0, z);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
